sa_seq_ctrl: RTL and testbench

Sequencer for the 8x8 weight-stationary systolic array. On a start command it loads one weight per array row, then streams `num_vec` activation vectors from the activation buffer. It drives the per-row skewed enables into the array and flags the result vectors as they leave the bottom edge. It sits between the host command interface and the array/buffer datapath and owns no arithmetic.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_seq_ctrl_if.sv | 30 +++
 rtl/skew_shift.sv | 26 ++
 rtl/sa_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_sa_seq_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared constants and FSM encoding for the systolic array sequencer.
package sa_pkg;

  localparam int SIZE     = 8;
  localparam int ADDR_W   = 8;
  localparam int ROW_W    = $clog2(SIZE);

  localparam int SKEW_LAT = SIZE;
  localparam int COL_LAT  = SIZE;
  localparam int RD_LAT   = 1;

  // Cycles from the last activation read until the last result flag has left.
  localparam int DRAIN_CYC = RD_LAT + (SKEW_LAT - 1) + COL_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Command and array/buffer control bundle between host, sequencer and datapath.
interface sa_seq_ctrl_if;

  logic                        start;
  logic [sa_pkg::ADDR_W-1:0]   num_vec;
  logic                        abort;
  logic                        ready;
  logic                        busy;
  logic                        w_load_en;
  logic [sa_pkg::ROW_W-1:0]    w_row_sel;
  logic                        act_rd_en;
  logic [sa_pkg::ADDR_W-1:0]   act_rd_addr;
  logic [sa_pkg::SIZE-1:0]     row_en;
  logic                        out_valid;
  logic [sa_pkg::ADDR_W-1:0]   out_idx;
  logic                        done;

  modport master (
    output start, num_vec, abort,
    input  ready, busy, w_load_en, w_row_sel, act_rd_en, act_rd_addr,
           row_en, out_valid, out_idx, done
  );

  modport slave (
    input  start, num_vec, abort,
    output ready, busy, w_load_en, w_row_sel, act_rd_en, act_rd_addr,
           row_en, out_valid, out_idx, done
  );

endinterface

// File: rtl/skew_shift.sv
// Shift chain with synchronous clear; exposes the NTAP deepest stages.
// Tap k of q is din delayed (DEPTH-NTAP+k+1) cycles; no backpressure.
module skew_shift #(
  parameter int DEPTH = 8,
  parameter int NTAP  = DEPTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            din,
  output logic [NTAP-1:0] q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign q = sr[DEPTH-1 -: NTAP];

endmodule

// File: rtl/sa_seq_ctrl.sv
// Weight-load / activation-stream sequencer for the SIZE x SIZE systolic array.
// Results flagged 3*SIZE+1 cycles after accept; start ignored while busy, abort cancels.
module sa_seq_ctrl
  import sa_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  sa_seq_ctrl_if.slave bus
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   n_q;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [ADDR_W-1:0]   idx_q;

  logic                ready_q;
  logic                busy_q;
  logic                wl_q;
  logic                rd_q;
  logic                done_q;
  logic [SIZE-1:0]     row_en;
  logic                ov;

  logic                accept;
  logic                kill;

  assign accept = (state == ST_IDLE) && bus.start;
  assign kill   = (state != ST_IDLE) && bus.abort;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nx = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (row_q == '0) state_nx = (n_q == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (addr_q == n_q - ADDR_W'(1)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    if (kill) state_nx = ST_IDLE;
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      n_q     <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      wl_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == ST_IDLE);
      busy_q  <= (state_nx != ST_IDLE);
      wl_q    <= (state_nx == ST_LOAD_W);
      rd_q    <= (state_nx == ST_STREAM);
      done_q  <= (state_nx == ST_DONE);

      if (accept) begin
        n_q    <= bus.num_vec;
        row_q  <= ROW_W'(SIZE - 1);
        addr_q <= '0;
        idx_q  <= '0;
      end else if (kill) begin
        row_q  <= '0;
        addr_q <= '0;
      end else begin
        if (state == ST_LOAD_W && row_q != '0) row_q <= row_q - ROW_W'(1);
        if (state == ST_STREAM && state_nx == ST_STREAM) addr_q <= addr_q + ADDR_W'(1);
        if (ov) idx_q <= idx_q + ADDR_W'(1);
      end

      if (state == ST_STREAM && state_nx == ST_DRAIN) begin
        drain_q <= DRAIN_W'(DRAIN_CYC - 1);
      end else if (state == ST_DRAIN && drain_q != '0) begin
        drain_q <= drain_q - DRAIN_W'(1);
      end
    end
  end

  skew_shift #(
    .DEPTH (SKEW_LAT),
    .NTAP  (SIZE)
  ) u_row_skew (
    .clk  (clk),
    .rstn (rstn),
    .clr  (kill),
    .din  (rd_q),
    .q    (row_en)
  );

  skew_shift #(
    .DEPTH (COL_LAT),
    .NTAP  (1)
  ) u_col_delay (
    .clk  (clk),
    .rstn (rstn),
    .clr  (kill),
    .din  (row_en[SIZE-1]),
    .q    (ov)
  );

  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.w_load_en   = wl_q;
  assign bus.w_row_sel   = row_q;
  assign bus.act_rd_en   = rd_q;
  assign bus.act_rd_addr = addr_q;
  assign bus.row_en      = row_en;
  assign bus.out_valid   = ov;
  assign bus.out_idx     = idx_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with a cycle-timing reference model.
module tb_sa_seq_ctrl;
  import sa_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sa_seq_ctrl_if bus();

  sa_seq_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a run is an accept cycle plus a vector count.
  bit en = 0;
  bit active = 0;
  bit rst_chk = 0;
  int acc = 0;
  int mn = 0;

  // Observed event log, cleared at every command issued by the driver.
  int done_cnt = 0, last_done = 0;
  int ov_cnt = 0, first_ov = -1, first_re7 = -1;
  int rd_cnt = 0, wl_cnt = 0, max_addr = 0;

  always @(negedge clk) begin
    int t, endc;
    bit run, idle;
    logic [SIZE-1:0] er;
    t    = cyc - acc;
    endc = (mn == 0) ? SIZE + 1 : 3 * SIZE + mn + 1;
    run  = active && t >= 1 && t <= endc;
    if (en) begin
      for (int i = 0; i < SIZE; i++)
        er[i] = run && (t >= SIZE + 2 + i) && (t <= SIZE + 1 + i + mn);
      chk("ready", bus.ready, !run);
      chk("busy", bus.busy, run);
      chk("w_load_en", bus.w_load_en, run && t <= SIZE);
      chk("act_rd_en", bus.act_rd_en, run && t >= SIZE + 1 && t <= SIZE + mn);
      chk("row_en", bus.row_en, er);
      chk("out_valid", bus.out_valid, run && t >= 3 * SIZE + 1 && t <= 3 * SIZE + mn);
      chk("done", bus.done, run && t == endc);
      if (run && t <= SIZE) chk("w_row_sel", bus.w_row_sel, SIZE - t);
      if (run && t >= SIZE + 1 && t <= SIZE + mn) chk("act_rd_addr", bus.act_rd_addr, t - SIZE - 1);
      if (run && t >= 3 * SIZE + 1 && t <= 3 * SIZE + mn) chk("out_idx", bus.out_idx, t - 3 * SIZE - 1);
      if (rst_chk) begin
        chk("rst_w_row_sel", bus.w_row_sel, 0);
        chk("rst_act_rd_addr", bus.act_rd_addr, 0);
        chk("rst_out_idx", bus.out_idx, 0);
      end
    end
    if (bus.w_load_en) wl_cnt++;
    if (bus.act_rd_en) begin
      rd_cnt++;
      if (int'(bus.act_rd_addr) > max_addr) max_addr = int'(bus.act_rd_addr);
    end
    if (bus.row_en[SIZE-1] && first_re7 < 0) first_re7 = cyc;
    if (bus.out_valid) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      last_done = cyc;
    end
    // Advance the model with the inputs applied for the coming edge.
    idle = !active || t > endc;
    rst_chk = 0;
    if (!rstn) begin
      active  = 0;
      rst_chk = 1;
      en      = 1;
    end else if (idle && bus.start) begin
      active = 1;
      acc    = cyc;
      mn     = int'(bus.num_vec);
    end else if (!idle && bus.abort) begin
      active = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n, output int a);
    bus.num_vec = n[ADDR_W-1:0];
    bus.start   = 1'b1;
    a           = cyc;
    ov_cnt = 0; first_ov = -1; first_re7 = -1;
    rd_cnt = 0; wl_cnt = 0; max_addr = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  initial begin
    int a, a2, d0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_vec = '0;
    repeat (3) step();
    rstn = 1'b1;
    chk("reset_ready", bus.ready, 1);
    chk("reset_busy", bus.busy, 0);

    go(3, a);
    wait_done("basic", 60);
    chk("basic_done_cycle", last_done - a, 28);
    chk("basic_wl_cnt", wl_cnt, 8);
    chk("basic_first_row7", first_re7 - a, 17);
    chk("basic_first_ov", first_ov - a, 25);
    chk("basic_ov_cnt", ov_cnt, 3);

    go(0, a);
    wait_done("zero", 30);
    chk("zero_done_cycle", last_done - a, 9);
    chk("zero_rd_cnt", rd_cnt, 0);
    chk("zero_wl_cnt", wl_cnt, 8);

    go(2, a);
    repeat (3) step();
    bus.start = 1'b1;
    bus.num_vec = 8'd5;
    step();
    bus.start = 1'b0;
    wait_done("busy_start", 60);
    chk("busy_done_cycle", last_done - a, 27);
    chk("busy_ov_cnt", ov_cnt, 2);

    go(10, a);
    repeat (11) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_row_en", bus.row_en, 0);
    chk("abort_rd_en", bus.act_rd_en, 0);
    d0 = done_cnt;
    repeat (30) step();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_ov", ov_cnt, 0);

    bus.abort = 1'b1;
    repeat (2) step();
    go(1, a);
    bus.abort = 1'b0;
    wait_done("start_over_abort", 60);
    chk("start_abort_done_cycle", last_done - a, 26);

    go(2, a);
    repeat (14) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_addr", bus.act_rd_addr, 0);
    go(1, a);
    wait_done("after_reset", 60);
    chk("after_reset_done_cycle", last_done - a, 26);
    chk("after_reset_ov_cnt", ov_cnt, 1);

    go(255, a);
    wait_done("max", 400);
    chk("max_done_cycle", last_done - a, 280);
    chk("max_ov_cnt", ov_cnt, 255);
    chk("max_rd_cnt", rd_cnt, 255);
    chk("max_last_addr", max_addr, 254);
    go(1, a2);
    chk("b2b_accept_cycle", a2 - a, 281);
    wait_done("b2b", 60);
    chk("b2b_done_cycle", last_done - a2, 26);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
